multdiv_issue_ctrl: RTL and testbench



---
 rtl/multdiv_pkg.sv | 26 ++
 rtl/multdiv_wait_counter.sv | 42 ++++
 rtl/multdiv_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the mult/div issue controller:
//     - state_e      : controller state encoding (IDLE, ISSUE, WAIT, DONE)
//     - DEF_WIDTH    : default operand/result width
//     - DEF_TAG_W    : default destination-register tag width
//     - DEF_TIMEOUT  : default number of WAIT cycles before an op is aborted
//     - CNT_W        : width of the WAIT-state cycle counter
// -----------------------------------------------------------------------------
package multdiv_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TAG_W   = 5;
    localparam int DEF_TIMEOUT = 40;

    // Wide enough for TIMEOUT values up to 64.
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : multdiv_pkg

// File: rtl/multdiv_wait_counter.sv
// -----------------------------------------------------------------------------
// multdiv_wait_counter
//   Counts cycles spent waiting for a unit to finish. Synchronous clear wins
//   over enable. The terminal flag is raised while the count equals
//   TIMEOUT-1, i.e. during the TIMEOUT-th enabled cycle after a clear.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset (count -> 0)
//   clear     in   synchronous clear of the count
//   enable    in   increment the count this cycle
//   terminal  out  count == TIMEOUT-1
// -----------------------------------------------------------------------------
module multdiv_wait_counter
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is always written with non-blocking (<=) so every
    // register samples pre-edge values, independent of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal = (count_q == CNT_W'(TIMEOUT - 1));

endmodule : multdiv_wait_counter

// File: rtl/multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl
//   Sequencer between the execute stage and the iterative multiplier/divider.
//   Accepts one request, latches its operands (held stable for the whole op,
//   since the divider reads them combinationally every cycle), pulses the
//   selected unit's start for one cycle, waits for that unit's resultRDY (or a
//   timeout), registers the result and hands it to writeback via valid/ready.
//
// Ports:
//   clock, reset_n                 clock / asynchronous active-low reset
//   in_valid, in_ready             request handshake from execute
//   in_is_div, in_opA, in_opB,     request payload (1 = divide, 0 = multiply)
//   in_tag
//   unit_opA, unit_opB             latched operands to both units
//   ctrl_MULT, ctrl_DIV            one-cycle start pulses
//   mult_result/exception/RDY      multiplier completion interface
//   div_result/exception/RDY       divider completion interface
//   out_valid, out_ready           result handshake to writeback
//   out_result, out_exception,     registered result payload
//   out_tag, out_timeout
//   busy                           pipeline stall, high whenever not IDLE
// -----------------------------------------------------------------------------
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_div,
    input  logic [WIDTH-1:0] in_opA,
    input  logic [WIDTH-1:0] in_opB,
    input  logic [TAG_W-1:0] in_tag,

    output logic [WIDTH-1:0] unit_opA,
    output logic [WIDTH-1:0] unit_opB,
    output logic             ctrl_MULT,
    output logic             ctrl_DIV,

    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_exception,
    input  logic             mult_resultRDY,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_exception,
    input  logic             div_resultRDY,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_exception,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic             busy
);

    state_e state_q, state_d;

    logic             is_div_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;

    logic [WIDTH-1:0] result_q;
    logic             exception_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             timeout_q;

    logic accept;
    logic sel_rdy;
    logic timeout_hit;
    logic in_issue, in_wait;

    // -------------------------------------------------------------------------
    // Handshake and selection
    // -------------------------------------------------------------------------
    assign in_issue = (state_q == ISSUE);
    assign in_wait  = (state_q == WAIT);

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Only the unit that was started may complete the op; the other unit's
    // RDY can be stale from an earlier operation.
    assign sel_rdy = is_div_q ? div_resultRDY : mult_resultRDY;

    // -------------------------------------------------------------------------
    // Wait counter: cleared in ISSUE, so the first WAIT cycle sees count 0.
    // -------------------------------------------------------------------------
    multdiv_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (in_issue),
        .enable   (in_wait),
        .terminal (timeout_hit)
    );

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (in_valid) state_d = ISSUE;
            // RDY is deliberately not looked at here: it may still be high
            // from the previous op's unit.
            ISSUE: state_d = WAIT;
            WAIT:  if (sel_rdy || timeout_hit) state_d = DONE;
            DONE: begin
                if (out_ready) state_d = in_valid ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture: operands only move on acceptance.
    // -------------------------------------------------------------------------
    // NOTE: these are plain flops, not a memory, so they take the async reset;
    // the unit operand outputs are required to read 0 while in reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            is_div_q <= 1'b0;
            tag_q    <= '0;
        end else if (accept) begin
            op_a_q   <= in_opA;
            op_b_q   <= in_opB;
            is_div_q <= in_is_div;
            tag_q    <= in_tag;
        end
    end

    // -------------------------------------------------------------------------
    // Result capture: written only on leaving WAIT, held through DONE.
    // A real completion beats a timeout in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            exception_q <= 1'b0;
            out_tag_q   <= '0;
            timeout_q   <= 1'b0;
        end else if (in_wait) begin
            if (sel_rdy) begin
                result_q    <= is_div_q ? div_result    : mult_result;
                exception_q <= is_div_q ? div_exception : mult_exception;
                out_tag_q   <= tag_q;
                timeout_q   <= 1'b0;
            end else if (timeout_hit) begin
                result_q    <= '0;
                exception_q <= 1'b1;
                out_tag_q   <= tag_q;
                timeout_q   <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so nothing from in_* reaches
    // out_* within a cycle.
    // -------------------------------------------------------------------------
    assign unit_opA      = op_a_q;
    assign unit_opB      = op_b_q;
    assign ctrl_DIV      = in_issue &&  is_div_q;
    assign ctrl_MULT     = in_issue && !is_div_q;

    assign out_valid     = (state_q == DONE);
    assign out_result    = result_q;
    assign out_exception = exception_q;
    assign out_tag       = out_tag_q;
    assign out_timeout   = timeout_q;
    assign busy          = (state_q != IDLE);

endmodule : multdiv_issue_ctrl

// File: tb/tb_multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue_ctrl
//   Directed bench for multdiv_issue_ctrl with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are sampled there
//   too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_multdiv_issue_ctrl;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 40;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_is_div;
    logic [WIDTH-1:0] in_opA, in_opB;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] unit_opA, unit_opB;
    logic             ctrl_MULT, ctrl_DIV;
    logic [WIDTH-1:0] mult_result;
    logic             mult_exception, mult_resultRDY;
    logic [WIDTH-1:0] div_result;
    logic             div_exception, div_resultRDY;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_exception;
    logic [TAG_W-1:0] out_tag;
    logic             out_timeout;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    multdiv_issue_ctrl #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_div      (in_is_div),
        .in_opA         (in_opA),
        .in_opB         (in_opB),
        .in_tag         (in_tag),
        .unit_opA       (unit_opA),
        .unit_opB       (unit_opB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_resultRDY (mult_resultRDY),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .div_resultRDY  (div_resultRDY),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_exception  (out_exception),
        .out_tag        (out_tag),
        .out_timeout    (out_timeout),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request and let it be accepted; returns in ISSUE.
    task automatic issue(input logic is_div, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        in_valid  = 1'b1;
        in_is_div = is_div;
        in_opA    = a;
        in_opB    = b;
        in_tag    = t;
        step();
        in_valid  = 1'b0;
    endtask

    // Hold the selected unit's RDY for one edge; returns in DONE.
    task automatic unit_done(input logic is_div, input logic [WIDTH-1:0] res, input logic exc);
        if (is_div) begin
            div_result = res; div_exception = exc; div_resultRDY = 1'b1;
        end else begin
            mult_result = res; mult_exception = exc; mult_resultRDY = 1'b1;
        end
        step();
        if (is_div) div_resultRDY = 1'b0;
        else        mult_resultRDY = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        in_valid       = 1'b0;
        in_is_div      = 1'b0;
        in_opA         = '0;
        in_opB         = '0;
        in_tag         = '0;
        mult_result    = '0;
        mult_exception = 1'b0;
        mult_resultRDY = 1'b0;
        div_result     = '0;
        div_exception  = 1'b0;
        div_resultRDY  = 1'b0;
        out_ready      = 1'b0;

        repeat (3) step();
        reset_n = 1'b1;
        step();

        // ---- reset state ----
        check("rst_busy",      busy,       0);
        check("rst_out_valid", out_valid,  0);
        check("rst_in_ready",  in_ready,   1);
        check("rst_unit_opA",  unit_opA,   0);
        check("rst_ctrl_div",  ctrl_DIV,   0);
        check("rst_ctrl_mult", ctrl_MULT,  0);
        check("rst_out_res",   out_result, 0);

        // ---- divide 100 / 7, tag 3 ----
        issue(1'b1, 32'd100, 32'd7, 5'd3);
        check("div_ctrl_div_issue",  ctrl_DIV,  1);
        check("div_ctrl_mult_issue", ctrl_MULT, 0);
        check("div_unit_opA_issue",  unit_opA,  100);
        check("div_busy",            busy,      1);
        check("div_in_ready",        in_ready,  0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("div_ctrl_div_wait",  ctrl_DIV,  0);
            check("div_ctrl_mult_wait", ctrl_MULT, 0);
            check("div_unit_opA_wait",  unit_opA,  100);
            check("div_out_valid_wait", out_valid, 0);
        end
        unit_done(1'b1, 32'd14, 1'b0);
        check("div_out_valid", out_valid,     1);
        check("div_out_res",   out_result,    14);
        check("div_out_tag",   out_tag,       3);
        check("div_out_exc",   out_exception, 0);
        check("div_out_to",    out_timeout,   0);
        check("div_unit_opA_done", unit_opA,  100);
        consume();
        check("div_idle_valid", out_valid, 0);
        check("div_idle_busy",  busy,      0);

        // ---- multiply -6 * 7 with a stuck divider RDY ----
        div_result    = 32'h1234;
        div_resultRDY = 1'b1;
        issue(1'b0, 32'hFFFF_FFFA, 32'd7, 5'd5);   // -6
        check("mul_ctrl_mult", ctrl_MULT, 1);
        check("mul_ctrl_div",  ctrl_DIV,  0);
        step();
        step();
        check("mul_div_rdy_ignored", out_valid, 0);
        check("mul_busy",            busy,      1);
        unit_done(1'b0, 32'hFFFF_FFD6, 1'b0);      // -42
        check("mul_out_valid", out_valid,  1);
        check("mul_out_res",   out_result, 32'hFFFF_FFD6);
        check("mul_out_tag",   out_tag,    5);
        div_resultRDY = 1'b0;
        consume();

        // ---- divide by zero: 5 / 0, tag 7 ----
        issue(1'b1, 32'd5, 32'd0, 5'd7);
        step();
        unit_done(1'b1, 32'd0, 1'b1);
        check("dbz_out_valid", out_valid,     1);
        check("dbz_out_exc",   out_exception, 1);
        check("dbz_out_res",   out_result,    0);
        check("dbz_out_to",    out_timeout,   0);
        check("dbz_unit_opB",  unit_opB,      0);

        // ---- backpressure in DONE with a pending request ----
        in_valid  = 1'b1;
        in_is_div = 1'b0;
        in_opA    = 32'd9;
        in_opB    = 32'd11;
        in_tag    = 5'd12;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready",  in_ready,      0);
            check("bp_ctrl_mult", ctrl_MULT,     0);
            check("bp_ctrl_div",  ctrl_DIV,      0);
            check("bp_out_valid", out_valid,     1);
            check("bp_out_exc",   out_exception, 1);
            check("bp_out_tag",   out_tag,       7);
            check("bp_unit_opA",  unit_opA,      5);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_ctrl_mult", ctrl_MULT, 1);
        check("b2b_ctrl_div",  ctrl_DIV,  0);
        check("b2b_unit_opA",  unit_opA,  9);
        check("b2b_out_valid", out_valid, 0);
        step();
        unit_done(1'b0, 32'd99, 1'b0);
        check("b2b_out_res", out_result, 99);
        check("b2b_out_tag", out_tag,    12);
        consume();

        // ---- stale RDY during ISSUE, then timeout ----
        issue(1'b1, 32'd50, 32'd5, 5'd9);
        div_result    = 32'd77;
        div_resultRDY = 1'b1;     // high only while in ISSUE
        step();
        div_resultRDY = 1'b0;
        repeat (TIMEOUT - 1) step();
        check("to_not_yet", out_valid, 0);
        step();
        check("to_out_valid", out_valid,     1);
        check("to_out_to",    out_timeout,   1);
        check("to_out_exc",   out_exception, 1);
        check("to_out_res",   out_result,    0);
        consume();

        // ---- reset in the middle of WAIT ----
        issue(1'b0, 32'd3, 32'd4, 5'd2);
        step();
        step();
        reset_n = 1'b0;
        #2;
        check("mid_rst_valid",    out_valid,   0);
        check("mid_rst_busy",     busy,        0);
        check("mid_rst_ctrl",     {ctrl_MULT, ctrl_DIV}, 0);
        check("mid_rst_unit_opA", unit_opA,    0);
        check("mid_rst_timeout",  out_timeout, 0);
        reset_n = 1'b1;
        issue(1'b0, 32'd3, 32'd4, 5'd2);
        check("post_rst_ctrl_mult", ctrl_MULT, 1);
        step();
        unit_done(1'b0, 32'd12, 1'b0);
        check("post_rst_valid", out_valid,  1);
        check("post_rst_res",   out_result, 12);
        check("post_rst_tag",   out_tag,    2);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_multdiv_issue_ctrl
